stdcore_sb2prf: RTL and testbench



---
 rtl/stdcore_pkg.sv | 48 ++++
 rtl/stdcore_rf_initseq.sv | 55 +++++
 rtl/stdcore_sb2prf.sv | 184 ++++++++++++++++++
 tb/tb_stdcore_sb2prf.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/stdcore_pkg.sv
// stdcore_pkg
// Shared definitions for the stdcore register-file family.
//   rf_state_e  : clear-sequencer state (CLR while initialising, RUN otherwise)
//   MAX_DW      : widest data word the lane-merge helper can handle
//   clog2       : ceiling log2, used to size indices and check AW against DEPTH
//   lane_merge  : per-lane select between new and old data under an active-low mask
package stdcore_pkg;

  typedef enum logic {
    CLR = 1'b0,
    RUN = 1'b1
  } rf_state_e;

  localparam int MAX_DW = 256;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

  // Lanes whose mask bit is 0 take new_data, all other lanes keep old_data.
  // Callers zero-extend to MAX_DW and truncate the result back to their width,
  // so lanes beyond the caller's word simply carry zeros.
  function automatic logic [MAX_DW-1:0] lane_merge(
    input logic [MAX_DW-1:0] new_data,
    input logic [MAX_DW-1:0] old_data,
    input logic [MAX_DW-1:0] mask_n,
    input int unsigned       lane_w
  );
    logic [MAX_DW-1:0] lane_bits;
    logic [MAX_DW-1:0] lane_sel;
    logic [MAX_DW-1:0] merged;
    merged    = old_data;
    lane_bits = (MAX_DW'(1) << lane_w) - MAX_DW'(1);
    for (int l = 0; l < MAX_DW; l++) begin
      if (!mask_n[l]) begin
        lane_sel = lane_bits << (l * lane_w);
        merged   = (merged & ~lane_sel) | (new_data & lane_sel);
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/stdcore_rf_initseq.sv
// stdcore_rf_initseq
// Post-reset clear sequencer: walks clr_addr from 0 to DEPTH-1, one entry per
// cycle, while busy is high, then parks in RUN until the next reset.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset; restarts the sequence at 0
//   busy     out  clear sequence in progress (registered)
//   clr_we   out  write strobe for the clear value into the storage array
//   clr_addr out  entry being cleared this cycle
module stdcore_rf_initseq
  import stdcore_pkg::*;
#(
  parameter int DEPTH    = 256,
  parameter int AW       = 8,
  parameter int INIT_CLR = 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  rf_state_e state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= (INIT_CLR != 0) ? CLR : RUN;
      busy     <= (INIT_CLR != 0);
      clr_addr <= '0;
    end else begin
      case (state)
        CLR: begin
          if (clr_addr == LAST_ADDR) begin
            state    <= RUN;
            busy     <= 1'b0;
            clr_addr <= '0;
          end else begin
            clr_addr <= clr_addr + AW'(1);
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

  // No clear write lands while reset is held, so a reset mid-clear restarts
  // cleanly from entry 0 on the first edge after release.
  assign clr_we = busy && !rst;

endmodule

// File: rtl/stdcore_sb2prf.sv
// stdcore_sb2prf
// Single-clock two-port register file: one masked write and one read per cycle,
// selectable read latency, optional same-cycle write-to-read bypass and an
// optional post-reset clear of every entry to INIT_VAL.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous active-high reset
//   wdata    in   write data
//   waddr    in   write address
//   we_n     in   write enable, active-low
//   be_n     in   lane write mask, active-low, one bit per MW-bit lane
//   raddr    in   read address
//   re_n     in   read enable, active-low
//   rdata    out  read data, held when no read completes
//   rvalid   out  one-cycle pulse marking rdata as a read result
//   busy     out  clear sequence in progress
//   coll     out  same-address read/write collision, aligned with rvalid
//   err_oob  out  out-of-range access, aligned with rdata timing
module stdcore_sb2prf
  import stdcore_pkg::*;
#(
  parameter int            DW       = 32,
  parameter int            DEPTH    = 256,
  parameter int            AW       = 8,
  parameter int            MW       = 8,
  parameter int            RLAT     = 1,
  parameter int            BYPASS   = 1,
  parameter int            INIT_CLR = 1,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     wdata,
  input  logic [AW-1:0]     waddr,
  input  logic              we_n,
  input  logic [DW/MW-1:0]  be_n,
  input  logic [AW-1:0]     raddr,
  input  logic              re_n,
  output logic [DW-1:0]     rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              coll,
  output logic              err_oob
);

  localparam int          NL      = DW / MW;
  localparam int          IW      = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam logic [AW:0] DEPTH_A = (AW + 1)'(DEPTH);

  // Parameter sanity, reported at elaboration.
  if (DW % MW != 0) begin : g_chk_mw
    $error("stdcore_sb2prf: DW (%0d) is not a multiple of MW (%0d)", DW, MW);
  end
  if (RLAT != 1 && RLAT != 2) begin : g_chk_rlat
    $error("stdcore_sb2prf: RLAT must be 1 or 2, got %0d", RLAT);
  end
  if (clog2(DEPTH) > AW) begin : g_chk_aw
    $error("stdcore_sb2prf: AW (%0d) too narrow for DEPTH (%0d)", AW, DEPTH);
  end
  if (DW > MAX_DW) begin : g_chk_dw
    $error("stdcore_sb2prf: DW (%0d) exceeds MAX_DW (%0d)", DW, MAX_DW);
  end

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  stdcore_rf_initseq #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .INIT_CLR (INIT_CLR)
  ) u_initseq (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic [DW-1:0] mem [DEPTH];

  logic          run_ok;
  logic          wr_req;
  logic          rd_req;
  logic          w_in;
  logic          r_in;
  logic          wr_ok;
  logic          hit;
  logic          mem_we;
  logic [IW-1:0] mem_idx;
  logic [DW-1:0] mem_wdata;
  logic [NL-1:0] lane_en;
  logic [DW-1:0] rd_old;
  logic [DW-1:0] rd_merged;
  logic [DW-1:0] rd_next;

  // User accesses are only accepted once the clear has finished and reset is low.
  assign run_ok = !busy && !rst;
  assign wr_req = run_ok && !we_n;
  assign rd_req = run_ok && !re_n;
  assign w_in   = {1'b0, waddr} < DEPTH_A;
  assign r_in   = {1'b0, raddr} < DEPTH_A;
  assign wr_ok  = wr_req && w_in;
  assign hit    = rd_req && wr_ok && (raddr == waddr);

  // Write port source: the clear sequencer owns the array while busy.
  always_comb begin
    if (clr_we) begin
      mem_we    = 1'b1;
      mem_idx   = clr_addr[IW-1:0];
      mem_wdata = INIT_VAL;
      lane_en   = '1;
    end else begin
      mem_we    = wr_ok;
      mem_idx   = waddr[IW-1:0];
      mem_wdata = wdata;
      lane_en   = ~be_n;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int l = 0; l < NL; l++) begin
        if (lane_en[l]) begin
          mem[mem_idx][l*MW +: MW] <= mem_wdata[l*MW +: MW];
        end
      end
    end
  end

  // Read data before the edge; out-of-range reads are forced to zero below,
  // so whatever the truncated index returns for them never reaches rdata.
  assign rd_old    = mem[raddr[IW-1:0]];
  assign rd_merged = DW'(lane_merge(MAX_DW'(wdata), MAX_DW'(rd_old), MAX_DW'(be_n), MW));
  assign rd_next   = !r_in                    ? '0        :
                     (hit && (BYPASS != 0))   ? rd_merged :
                                                rd_old;

  logic          s1_valid;
  logic          s1_coll;
  logic          s1_err;
  logic [DW-1:0] s1_data;

  // First read stage: sampled array word (with bypass merge) plus status flags.
  // A read and an out-of-range write in the same cycle share one err pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_coll  <= 1'b0;
      s1_err   <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_req;
      s1_coll  <= hit;
      s1_err   <= (rd_req && !r_in) || (wr_req && !w_in);
      if (rd_req) begin
        s1_data <= rd_next;
      end
    end
  end

  if (RLAT == 2) begin : g_rlat2
    always_ff @(posedge clk) begin
      if (rst) begin
        rvalid  <= 1'b0;
        coll    <= 1'b0;
        err_oob <= 1'b0;
        rdata   <= '0;
      end else begin
        rvalid  <= s1_valid;
        coll    <= s1_coll;
        err_oob <= s1_err;
        if (s1_valid) begin
          rdata <= s1_data;
        end
      end
    end
  end else begin : g_rlat1
    assign rvalid  = s1_valid;
    assign coll    = s1_coll;
    assign err_oob = s1_err;
    assign rdata   = s1_data;
  end

endmodule

// File: tb/tb_stdcore_sb2prf.sv
// tb_stdcore_sb2prf
// Scoreboard bench for stdcore_sb2prf: the driver predicts each response from a
// plain array model of the register file and queues it; an independent monitor
// pops and compares whenever the DUT raises rvalid or err_oob.
module tb_stdcore_sb2prf;

  localparam int          DW       = 32;
  localparam int          DEPTH    = 12;
  localparam int          AW       = 4;
  localparam int          MW       = 8;
  localparam int          NL       = DW / MW;
  localparam int          RLAT     = 2;
  localparam int          BYPASS   = 1;
  localparam int          INIT_CLR = 1;
  localparam logic [31:0] INIT_VAL = 32'hA5A5A5A5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] wdata = '0;
  logic [AW-1:0] waddr = '0;
  logic          we_n = 1'b1;
  logic [NL-1:0] be_n = '1;
  logic [AW-1:0] raddr = '0;
  logic          re_n = 1'b1;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          busy;
  logic          coll;
  logic          err_oob;

  stdcore_sb2prf #(
    .DW       (DW),
    .DEPTH    (DEPTH),
    .AW       (AW),
    .MW       (MW),
    .RLAT     (RLAT),
    .BYPASS   (BYPASS),
    .INIT_CLR (INIT_CLR),
    .INIT_VAL (INIT_VAL)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wdata   (wdata),
    .waddr   (waddr),
    .we_n    (we_n),
    .be_n    (be_n),
    .raddr   (raddr),
    .re_n    (re_n),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .busy    (busy),
    .coll    (coll),
    .err_oob (err_oob)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          is_read;
    logic [DW-1:0] data;
    logic          coll;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] model_mem [DEPTH];
  int            n_vec  = 0;
  int            n_fail = 0;

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, predict the response and update the model.
  task automatic applyStimulus(input bit we, input int wa, input logic [DW-1:0] wd,
                               input logic [NL-1:0] be, input bit re, input int ra);
    exp_t          e;
    logic [DW-1:0] merged;
    bit            rd_oob;
    bit            wr_oob;
    rd_oob = (ra >= DEPTH);
    wr_oob = (wa >= DEPTH);
    we_n   = !we;
    waddr  = AW'(wa);
    wdata  = wd;
    be_n   = be;
    re_n   = !re;
    raddr  = AW'(ra);
    merged = '0;
    if (!wr_oob) begin
      merged = model_mem[wa];
      for (int l = 0; l < NL; l++) begin
        if (!be[l]) merged[l*MW +: MW] = wd[l*MW +: MW];
      end
    end
    e.is_read = re;
    e.coll    = re && we && (ra == wa) && !rd_oob;
    e.err     = (re && rd_oob) || (we && wr_oob);
    e.data    = '0;
    if (re && !rd_oob) begin
      e.data = (e.coll && BYPASS != 0) ? merged : model_mem[ra];
    end
    if (re || e.err) exp_q.push_back(e);
    if (we && !wr_oob) model_mem[wa] = merged;
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    we_n = 1'b1;
    re_n = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic checkClearLength(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    checkOutput(name, 32'(n), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) model_mem[i] = INIT_VAL;
  endtask

  // Monitor: compares every presented output against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (rvalid || err_oob)) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("[TB] FAIL unexpected_output: rvalid=%b err_oob=%b, expected no output",
                   rvalid, err_oob);
        end else begin
          e = exp_q.pop_front();
          checkOutput("rvalid", DW'(rvalid), DW'(e.is_read));
          if (e.is_read) checkOutput("rdata", rdata, e.data);
          checkOutput("coll", DW'(coll), DW'(e.coll));
          checkOutput("err_oob", DW'(err_oob), DW'(e.err));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation exceeded its time budget");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail + 1);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    checkOutput("reset_rdata", rdata, '0);
    checkOutput("reset_rvalid", DW'(rvalid), '0);
    checkOutput("reset_coll", DW'(coll), '0);
    checkOutput("reset_err_oob", DW'(err_oob), '0);
    checkOutput("reset_busy", DW'(busy), DW'(INIT_CLR));
    rst = 1'b0;
    checkClearLength("clear_busy_cycles");

    // Single read: measure latency from issue to rvalid.
    applyStimulus(0, 0, '0, '1, 1, 4);
    we_n = 1'b1;
    re_n = 1'b1;
    lat = 1;
    while (!rvalid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("read_latency", 32'(lat), 32'(RLAT));
    idleCycles(3);

    // Every entry holds the clear value; streamed back to back.
    for (int a = 0; a < DEPTH; a++) applyStimulus(0, 0, '0, '1, 1, a);
    idleCycles(4);

    // Masked write over zero contents.
    applyStimulus(1, 3, 32'h0, 4'b0000, 0, 0);
    applyStimulus(1, 3, 32'h11223344, 4'b1010, 0, 0);
    applyStimulus(0, 0, '0, '1, 1, 3);

    // Collision with bypass, then a plain re-read.
    applyStimulus(1, 5, 32'hFFFFFFFF, 4'b0000, 0, 0);
    applyStimulus(1, 5, 32'h12345678, 4'b0011, 1, 5);
    applyStimulus(0, 0, '0, '1, 1, 5);

    // Write then read the same address on the next cycle.
    applyStimulus(1, 7, 32'hCAFEF00D, 4'b0000, 0, 0);
    applyStimulus(0, 0, '0, '1, 1, 7);

    // Out-of-range accesses, alone and together, then confirm nothing moved.
    applyStimulus(1, 12, 32'hDEADBEEF, 4'b0000, 1, 13);
    applyStimulus(1, 14, 32'h01010101, 4'b0000, 0, 0);
    applyStimulus(0, 0, '0, '1, 1, 15);
    applyStimulus(1, 2, 32'h0BADF00D, 4'b0000, 1, 12);
    for (int a = 0; a < DEPTH; a++) applyStimulus(0, 0, '0, '1, 1, a);
    idleCycles(4);

    // Random traffic, addresses include the out-of-range region.
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom(),
                    NL'($urandom()), $urandom_range(0, 3) != 0, $urandom_range(0, 15));
    end
    idleCycles(RLAT + 3);
    checkOutput("queue_drained_random", 32'(exp_q.size()), 32'(0));

    // Reset mid-clear: restart from entry 0 and run a full clear again.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (7) @(negedge clk);
    checkOutput("busy_mid_clear", DW'(busy), DW'(1));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkClearLength("restart_busy_cycles");
    for (int a = 0; a < DEPTH; a++) applyStimulus(0, 0, '0, '1, 1, a);
    idleCycles(RLAT + 3);
    checkOutput("queue_drained_final", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
